// File: rtl/writeback_queue.sv
// Writeback queue: merges load-unit and ALU results into one register-file write port.
// Optional pending-write lookup (forwarding) is enabled by defining WBQ_FWD_EN.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_addr,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_addr,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  output logic [4:0]               regfile_addr3,
  output logic [31:0]              regfile_wdata,
  output logic                     RegWrite,
  input  logic [4:0]               fwd_addr1,
  input  logic [4:0]               fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [31:0]              fwd_data1,
  output logic [31:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic             mem_m;
  logic             mem_enq;
  logic             alu_enq;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;

  // Readiness looks only at the registered count and ignores the same-cycle pop.
  always_comb begin
    mem_m     = mem_valid && (mem_addr != 5'd0);
    mem_ready = (count_q < DEPTH_C);
    alu_ready = ((count_q + (PTR_W+1)'(mem_m)) < DEPTH_C);
    mem_enq   = mem_valid && mem_ready && (mem_addr != 5'd0);
    alu_enq   = alu_valid && alu_ready && (alu_addr != 5'd0);
    pop       = (count_q != '0);
    alu_slot  = tail_q + PTR_W'(mem_enq);
    head_d    = head_q + PTR_W'(pop);
    tail_d    = tail_q + PTR_W'(mem_enq) + PTR_W'(alu_enq);
    count_d   = count_q + (PTR_W+1)'(mem_enq) + (PTR_W+1)'(alu_enq) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Mem lands first (older), ALU in the following slot.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      addr_q[tail_q] <= mem_addr;
      data_q[tail_q] <= mem_data;
    end
    if (alu_enq) begin
      addr_q[alu_slot] <= alu_addr;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_comb begin
    RegWrite      = pop;
    regfile_addr3 = pop ? addr_q[head_q] : 5'd0;
    regfile_wdata = pop ? data_q[head_q] : 32'd0;
  end

  assign count = count_q;

`ifdef WBQ_FWD_EN
  // Walk oldest to youngest so the last match wins.
  function automatic logic [32:0] lookup(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count_q) && (a != 5'd0) &&
          (addr_q[head_q + PTR_W'(i)] == a)) begin
        r = {1'b1, data_q[head_q + PTR_W'(i)]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(fwd_addr1);
    {fwd_hit2, fwd_data2} = lookup(fwd_addr2);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr1, fwd_addr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = 32'd0;
  assign fwd_data2  = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=4); forwarding expectations follow WBQ_FWD_EN.
`timescale 1ns/1ps
module tb_writeback_queue;
  localparam int DEPTH = 4;
`ifdef WBQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, alu_valid, mem_ready, alu_ready, RegWrite;
  logic [4:0]  mem_addr, alu_addr, regfile_addr3, fwd_addr1, fwd_addr2;
  logic [31:0] mem_data, alu_data, regfile_wdata, fwd_data1, fwd_data2;
  logic        fwd_hit1, fwd_hit2;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  qa [$];
  logic [31:0] qd [$];

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .regfile_addr3(regfile_addr3), .regfile_wdata(regfile_wdata), .RegWrite(RegWrite),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic [4:0]  ma, aa;
    logic [31:0] md, ad;
    logic        exp_mr, exp_ar;
    int          sz;

    rst_n = 1'b0;
    fwd_addr1 = 5'd0; fwd_addr2 = 5'd0;
    idle();
    @(negedge clk);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_regwrite", 32'(RegWrite), 32'd0);
    check_eq("rst_addr3", 32'(regfile_addr3), 32'd0);
    check_eq("rst_wdata", regfile_wdata, 32'd0);
    check_eq("rst_mem_ready", 32'(mem_ready), 32'd1);
    check_eq("rst_alu_ready", 32'(alu_ready), 32'd1);
    check_eq("rst_fwd_hit", 32'(fwd_hit1), 32'd0);
    rst_n = 1'b1;
    step();

    // Single ALU write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    check_eq("single_alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    check_eq("single_regwrite", 32'(RegWrite), 32'd1);
    check_eq("single_addr3", 32'(regfile_addr3), 32'd5);
    check_eq("single_wdata", regfile_wdata, 32'hDEADBEEF);
    check_eq("single_count", 32'(count), 32'd1);
    step();
    check_eq("single_count_after", 32'(count), 32'd0);
    check_eq("single_regwrite_after", 32'(RegWrite), 32'd0);
    check_eq("single_wdata_after", regfile_wdata, 32'd0);

    // Same-cycle mem and ALU to same address
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    check_eq("dual_mem_ready", 32'(mem_ready), 32'd1);
    check_eq("dual_alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    fwd_addr1 = 5'd3;
    #1;
    check_eq("dual_count", 32'(count), 32'd2);
    check_eq("dual_first_wdata", regfile_wdata, 32'h11);
    check_eq("dual_fwd_hit", 32'(fwd_hit1), FWD ? 32'd1 : 32'd0);
    check_eq("dual_fwd_data", fwd_data1, FWD ? 32'h22 : 32'd0);
    step();
    check_eq("dual_second_wdata", regfile_wdata, 32'h22);
    check_eq("dual_second_addr3", 32'(regfile_addr3), 32'd3);
    check_eq("dual_count2", 32'(count), 32'd1);
    fwd_addr1 = 5'd0;
    step();
    check_eq("dual_drained", 32'(count), 32'd0);

    // Back-pressure at count=3
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    step();
    drive(1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6);
    check_eq("bp_alu_ready_c2", 32'(alu_ready), 32'd1);
    step();
    drive(1'b1, 5'd7, 32'hB7, 1'b1, 5'd8, 32'hB8);
    check_eq("bp_count3", 32'(count), 32'd3);
    check_eq("bp_mem_ready", 32'(mem_ready), 32'd1);
    check_eq("bp_alu_ready", 32'(alu_ready), 32'd0);
    check_eq("bp_head_a2", regfile_wdata, 32'hA2);
    step();
    idle();
    check_eq("bp_count_stays", 32'(count), 32'd3);
    check_eq("bp_wdata_a4", regfile_wdata, 32'hA4);
    step();
    check_eq("bp_wdata_a6", regfile_wdata, 32'hA6);
    step();
    check_eq("bp_wdata_b7", regfile_wdata, 32'hB7);
    check_eq("bp_addr_b7", 32'(regfile_addr3), 32'd7);
    step();
    check_eq("bp_drained", 32'(count), 32'd0);

    // Address-zero discard
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    check_eq("zero_alu_ready", 32'(alu_ready), 32'd1);
    check_eq("zero_fwd_hit", 32'(fwd_hit1), 32'd0);
    step();
    idle();
    check_eq("zero_count", 32'(count), 32'd0);
    check_eq("zero_regwrite", 32'(RegWrite), 32'd0);

    // Continuous dual enqueue against a reference FIFO
    for (int c = 0; c < 20; c++) begin
      ma = 5'($urandom_range(31, 0)); aa = 5'($urandom_range(31, 0));
      md = $urandom; ad = $urandom;
      drive(1'b1, ma, md, 1'b1, aa, ad);
      sz = qa.size();
      exp_mr = (sz < DEPTH);
      exp_ar = ((sz + ((ma != 5'd0) ? 1 : 0)) < DEPTH);
      check_eq("stream_mem_ready", 32'(mem_ready), 32'(exp_mr));
      check_eq("stream_alu_ready", 32'(alu_ready), 32'(exp_ar));
      check_eq("stream_count", 32'(count), 32'(sz));
      check_eq("stream_count_le4", 32'(count <= 3'd4), 32'd1);
      check_eq("stream_regwrite", 32'(RegWrite), 32'(sz != 0));
      if (sz != 0) begin
        check_eq("stream_addr3", 32'(regfile_addr3), 32'(qa[0]));
        check_eq("stream_wdata", regfile_wdata, qd[0]);
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (exp_mr && ma != 5'd0) begin qa.push_back(ma); qd.push_back(md); end
      if (exp_ar && aa != 5'd0) begin qa.push_back(aa); qd.push_back(ad); end
      step();
    end
    idle();
    for (int c = 0; c < 8 && qa.size() != 0; c++) begin
      check_eq("drain_addr3", 32'(regfile_addr3), 32'(qa[0]));
      check_eq("drain_wdata", regfile_wdata, qd[0]);
      void'(qa.pop_front());
      void'(qd.pop_front());
      step();
    end
    check_eq("drain_empty", 32'(count), 32'd0);

    // Mid-operation reset
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    step();
    idle();
    check_eq("mrst_count_pre", 32'(count), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mrst_regwrite", 32'(RegWrite), 32'd0);
    check_eq("mrst_count", 32'(count), 32'd0);
    check_eq("mrst_wdata", regfile_wdata, 32'd0);
    check_eq("mrst_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("mrst_post_regwrite", 32'(RegWrite), 32'd0);
    check_eq("mrst_post_count", 32'(count), 32'd0);
    step();
    check_eq("mrst_post_regwrite2", 32'(RegWrite), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of pending-write entries; it is a power of two and at least 2.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, an asynchronous, active-low reset.
REQ-004 The module SHALL have ports mem_valid (in, 1), mem_addr (in, 5), mem_data (in, 32) and mem_ready (out, 1), forming the load-unit result channel.
REQ-005 The module SHALL have ports alu_valid (in, 1), alu_addr (in, 5), alu_data (in, 32) and alu_ready (out, 1), forming the ALU result channel.
REQ-006 The module SHALL have ports regfile_addr3 (out, 5), regfile_wdata (out, 32) and RegWrite (out, 1), forming the register-file write port.
REQ-007 The module SHALL have ports fwd_addr1 and fwd_addr2 (in, 5), fwd_hit1 and fwd_hit2 (out, 1), and fwd_data1 and fwd_data2 (out, 32), forming the pending-write lookup.
REQ-008 The module SHALL have port count, output, log2(DEPTH)+1 bits, giving the current number of occupied entries.

Function
REQ-009 The module SHALL hold pending writes in a circular FIFO of DEPTH {addr, data} entries with head and tail pointers that wrap modulo DEPTH.
REQ-010 A channel handshake SHALL complete in a cycle where valid=1 and ready=1 at the rising edge.
REQ-011 mem_ready SHALL equal (count < DEPTH), using the registered count only.
REQ-012 alu_ready SHALL equal (count + m < DEPTH), where m=1 if mem_valid=1 and mem_addr!=0, else m=0.
REQ-013 The ready computations SHALL ignore any same-cycle drain, so back-pressure is conservative.
REQ-014 A completed handshake with addr=0 SHALL be accepted and discarded, allocating no entry.
REQ-015 When both channels complete a handshake in the same cycle, the mem entry SHALL be enqueued first (older) and the alu entry second.
REQ-016 Up to two enqueues and one dequeue SHALL be possible in any single cycle.
REQ-017 RegWrite SHALL equal (count != 0).
REQ-018 regfile_addr3 and regfile_wdata SHALL present the head entry while RegWrite=1, and SHALL be 0 while RegWrite=0.
REQ-019 The head SHALL be popped on every rising edge where RegWrite=1; the register file never stalls.
REQ-020 Enqueue-to-write latency SHALL be 1 cycle from the handshake edge when the queue is empty.
REQ-021 The next count SHALL equal count + enqueues - (RegWrite ? 1 : 0).
REQ-022 count SHALL never exceed DEPTH.
REQ-023 Write order at the register file SHALL equal enqueue order, including repeated writes to the same address.

Reset
REQ-024 While rst_n=0, the module SHALL asynchronously clear head, tail and count to 0.
REQ-025 While rst_n=0, the module SHALL force RegWrite=0, regfile_addr3=0, regfile_wdata=0, fwd_hit*=0 and fwd_data*=0.
REQ-026 While rst_n=0, mem_ready SHALL be 1, and alu_ready SHALL follow REQ-012 with count=0.
REQ-027 Entry storage SHALL need no reset, because it is unobservable while empty.
REQ-028 A reset asserted mid-operation SHALL discard all pending writes, with no partial write issued.
REQ-029 Release of rst_n SHALL take effect synchronously to clk.

Configuration
REQ-030 With macro WBQ_FWD_EN defined, fwd_hitN SHALL be 1 when any occupied entry (head included) has addr == fwd_addrN and fwd_addrN != 0.
REQ-031 With WBQ_FWD_EN defined, fwd_dataN SHALL carry the youngest matching entry's data, or 0 when there is no hit.
REQ-032 With WBQ_FWD_EN defined, the lookup SHALL be purely combinational from stored entries and SHALL exclude same-cycle inputs.
REQ-033 With WBQ_FWD_EN undefined, fwd_hit1, fwd_hit2, fwd_data1 and fwd_data2 SHALL be constant 0, and no comparator logic SHALL be present.

Verification
REQ-034 The bench SHALL cover: empty queue, single alu handshake {addr=5, data=0xDEADBEEF} -> next cycle RegWrite=1, regfile_addr3=5, regfile_wdata=0xDEADBEEF, then count=0.
REQ-035 The bench SHALL cover: same-cycle mem {3, 0x11} and alu {3, 0x22} -> writes appear as 0x11 then 0x22 on consecutive cycles; with WBQ_FWD_EN defined, fwd_addr1=3 in the cycle after the handshake gives hit=1, data=0x22.
REQ-036 The bench SHALL cover: DEPTH=4, count=3, both valid with nonzero addresses -> mem_ready=1, alu_ready=0; count stays 3 (one in, one out).
REQ-037 The bench SHALL cover: alu handshake with addr=0 -> count unchanged, no RegWrite pulse, fwd_addr1=0 gives hit=0.
REQ-038 The bench SHALL cover: continuous dual enqueue for 20 cycles with random addresses -> pointers wrap, count never exceeds 4, and the write sequence matches a reference FIFO model.
REQ-039 The bench SHALL cover: rst_n pulled low with count=2 -> RegWrite=0 immediately, count=0, and no write of the discarded entries after release.
